// File: rtl/ahb_uart_tx.sv
// ahb_uart_tx: AHB-Lite slave with a FIFO-buffered 8N1 serial transmitter.
// Bus writes queue bytes into a circular FIFO; a baud-rate serializer drains
// them onto uart_tx. Zero wait states, always OKAY. A level interrupt reports
// that the transmitter has fully drained.
module ahb_uart_tx #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        uart_tx,
    output logic        tx_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [CW-1:0] FULL_CT = CW'(FIFO_DEPTH);

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Bus pipeline (address phase captured, consumed in data phase)
    logic        r_valid;
    logic        r_write;
    logic [1:0]  r_addr;

    // Control / status
    logic        r_en;
    logic        r_ie;
    logic        r_ovf;

    // FIFO
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Serializer
    state_t      r_state;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_tx;

    logic        w_aphase;
    logic        w_wr_data;
    logic        w_wr_status;
    logic        w_wr_ctrl;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_busy;
    logic [8:0]  w_count9;
    logic        w_unused_bits;

    assign w_aphase    = HSEL & HTRANS[1] & HREADY;
    assign w_wr_data   = r_valid & r_write & (r_addr == A_DATA);
    assign w_wr_status = r_valid & r_write & (r_addr == A_STATUS);
    assign w_wr_ctrl   = r_valid & r_write & (r_addr == A_CTRL);

    // Full is judged on the current count, so a same-cycle pop never rescues
    // a write that arrives while the FIFO is full.
    assign w_full   = (r_count == FULL_CT);
    assign w_empty  = (r_count == '0);
    assign w_push   = w_wr_data & ~w_full;
    assign w_pop    = (r_state == S_IDLE) & r_en & ~w_empty;
    assign w_busy   = (r_state != S_IDLE);
    assign w_count9 = 9'(r_count);

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign uart_tx   = r_tx;
    assign tx_irq    = r_ie & w_empty & (r_state == S_IDLE);

    // Inputs that carry no meaning for this slave
    assign w_unused_bits = ^{HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HWDATA[31:8]};

    // Capture address-phase information for the following data phase
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= 2'd0;
        end else begin
            r_valid <= w_aphase;
            if (w_aphase) begin
                r_write <= HWRITE;
                r_addr  <= HADDR[3:2];
            end
        end
    end

    // CTRL register: transmit enable and interrupt enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en <= 1'b1;
            r_ie <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_en <= HWDATA[0];
            r_ie <= HWDATA[1];
        end
    end

    // FIFO storage; no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= HWDATA[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_wr_data & w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status & HWDATA[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Serializer: start bit, 8 data bits LSB first, stop bit; output registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_baud  <= DIV_M1;
                        r_bit   <= '0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud == '0) begin
                        r_baud  <= DIV_M1;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_baud == '0) begin
                        r_baud <= DIV_M1;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_baud == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Read data for the current data phase, decoded from the captured address
    always_comb begin
        HRDATA = 32'd0;
        if (r_valid & ~r_write) begin
            case (r_addr)
                A_STATUS: HRDATA = {15'd0, w_count9, 4'd0, r_ovf, w_busy, w_empty, w_full};
                A_CTRL:   HRDATA = {30'd0, r_ie, r_en};
                default:  HRDATA = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_uart_tx.sv
// Directed testbench for ahb_uart_tx with CLK_DIV=4 and FIFO_DEPTH=4.
module tb_ahb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        uart_tx;
    logic        tx_irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_uart_tx #(
        .CLK_DIV   (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HSIZE    (HSIZE),
        .HPROT    (HPROT),
        .HWRITE   (HWRITE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP),
        .HRDATA   (HRDATA),
        .uart_tx  (uart_tx),
        .tx_irq   (tx_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("%s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = addr;
        tick();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HWDATA = data;
        tick();
        $display("write addr=0x%0h data=0x%08h", addr, data);
    endtask

    // Returns the data-phase value; the data phase is still open on return
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b0;
        HADDR  = addr;
        tick();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        data   = HRDATA;
        $display("read  addr=0x%0h data=0x%08h", addr, data);
    endtask

    // Serial frame bit idx (0 start, 1..8 data LSB first, 9 stop)
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int frame;
        int off;
        logic expb;

        rst    = 1'b1;
        HSEL   = 1'b0;
        HADDR  = 32'd0;
        HTRANS = 2'b00;
        HSIZE  = 3'b010;
        HPROT  = 4'b0011;
        HWRITE = 1'b0;
        HWDATA = 32'd0;
        HREADY = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("reset_tx", {31'd0, uart_tx}, 32'd1);
        chk("reset_irq", {31'd0, tx_irq}, 32'd0);
        chk("reset_hrdata", HRDATA, 32'd0);
        chk("reset_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        chk("reset_hresp", {31'd0, HRESP}, 32'd0);
        bus_read(32'h4, d);
        chk("status_reset", d, 32'h0000_0002);
        bus_read(32'h8, d);
        chk("ctrl_reset", d, 32'h0000_0001);

        // Single byte 0x55: falls one cycle after commit, 40-cycle frame
        bus_write(32'h0, 32'h55);
        chk("tx_at_commit", {31'd0, uart_tx}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("frame_55", {31'd0, uart_tx}, {31'd0, frame_bit(8'h55, i / 4)});
        end
        tick();
        chk("idle_after_55", {31'd0, uart_tx}, 32'd1);
        bus_read(32'h4, d);
        chk("status_after_55", d, 32'h0000_0002);

        // Overflow with transmitter disabled
        bus_write(32'h8, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            bus_write(32'h0, 32'(i));
        end
        bus_read(32'h4, d);
        chk("status_full_ovf", d, 32'h0000_0409);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("tx_held_disabled", {31'd0, uart_tx}, 32'd1);
        end

        // Enable: 0x01..0x04 with 41-cycle spacing, 0x05 never sent
        bus_write(32'h8, 32'h1);
        for (int t = 0; t < 4 * 41 + 20; t++) begin
            tick();
            frame = t / 41;
            off   = t % 41;
            if (frame < 4 && off < 40) begin
                expb = frame_bit(8'(frame + 1), off / 4);
            end else begin
                expb = 1'b1;
            end
            chk("burst_frames", {31'd0, uart_tx}, {31'd0, expb});
        end
        bus_read(32'h4, d);
        chk("status_ovf_sticky", d, 32'h0000_000A);
        bus_write(32'h4, 32'h8);
        bus_read(32'h4, d);
        chk("status_ovf_clear", d, 32'h0000_0002);

        // Interrupt: low from commit through the stop bit, high in first IDLE
        bus_write(32'h8, 32'h3);
        chk("irq_idle_empty", {31'd0, tx_irq}, 32'd1);
        bus_write(32'h0, 32'hA3);
        chk("irq_at_commit", {31'd0, tx_irq}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("irq_during_frame", {31'd0, tx_irq}, 32'd0);
            chk("frame_a3", {31'd0, uart_tx}, {31'd0, frame_bit(8'hA3, i / 4)});
        end
        tick();
        chk("irq_after_stop", {31'd0, tx_irq}, 32'd1);

        // Reset in the middle of data bit 3 of 0xFF with two bytes queued
        bus_write(32'h0, 32'hFF);
        bus_write(32'h0, 32'hFF);
        bus_write(32'h0, 32'hFF);
        bus_read(32'h4, d);
        chk("status_two_queued", d, 32'h0000_0204);
        repeat (14) tick();
        chk("tx_data_bit3", {31'd0, uart_tx}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("tx_after_reset", {31'd0, uart_tx}, 32'd1);
        chk("irq_after_reset", {31'd0, tx_irq}, 32'd0);
        bus_read(32'h4, d);
        chk("status_after_reset", d, 32'h0000_0002);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("no_frame_after_reset", {31'd0, uart_tx}, 32'd1);
        end
        bus_read(32'h8, d);
        chk("ctrl_after_reset", d, 32'h0000_0001);

        // Pipelined DATA write followed directly by STATUS read
        tick();
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = 32'h0;
        tick();
        HWDATA = 32'h3C;
        HWRITE = 1'b0;
        HADDR  = 32'h4;
        tick();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        $display("pipelined write 0x3C then read status data=0x%08h", HRDATA);
        chk("pipelined_status", HRDATA, 32'h0000_0100);
        chk("pipelined_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        chk("pipelined_hresp", {31'd0, HRESP}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("frame_3c", {31'd0, uart_tx}, {31'd0, frame_bit(8'h3C, i / 4)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
